// File: rtl/signed_seg_display_if.sv
// rtl/signed_seg_display_if.sv - capture handshake between the signed datapath and the display stage
interface signed_seg_display_if;
  logic [7:0] din;
  logic       din_valid;
  logic       busy;

  modport master (output din, output din_valid, input busy);
  modport slave  (input din, input din_valid, output busy);
endinterface

// File: rtl/signed_seg_display.sv
// rtl/signed_seg_display.sv - signed 8-bit value to sign + 3 BCD digits on a 4-digit muxed 7-segment display
module signed_seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  signed_seg_display_if.slave   bus,
  output logic [3:0]            an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [3:0] SYM_DASH  = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] sh;
  logic [19:0] sh_adj;
  logic [19:0] sh_shift;
  logic [2:0]  step;
  logic        sign_r;
  logic [7:0]  mag_in;

  logic        disp_sign;
  logic [3:0]  disp_h, disp_t, disp_o;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    sym;
  logic [3:0]    an_nxt;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // internal codes are active-low; polarity is applied once at the pins
  function automatic logic [6:0] seg_code(input logic [3:0] s);
    case (s)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      4'd10:   return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  assign mag_in   = bus.din[7] ? (~bus.din + 8'd1) : bus.din;
  assign sh_adj   = {dd_adj(sh[19:16]), dd_adj(sh[15:12]), dd_adj(sh[11:8]), sh[7:0]};
  assign sh_shift = sh_adj << 1;
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.din_valid) state_nxt = CONV;
      CONV:    if (step == 3'd7) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      step      <= '0;
      sign_r    <= 1'b0;
      disp_sign <= 1'b0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            sign_r <= bus.din[7];
            sh     <= {12'd0, mag_in};
            step   <= '0;
          end
        end
        CONV: begin
          sh   <= sh_shift;
          step <= step + 3'd1;
        end
        LOAD: begin
          disp_sign <= sign_r;
          disp_h    <= sh[19:16];
          disp_t    <= sh[15:12];
          disp_o    <= sh[11:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // leading-zero blanking: tens only blank when hundreds are blank too
  always_comb begin
    sym    = SYM_BLANK;
    an_nxt = ~(4'b0001 << idx);
    case (idx)
      2'd0: sym = disp_o;
      2'd1: sym = (disp_h == 4'd0 && disp_t == 4'd0) ? SYM_BLANK : disp_t;
      2'd2: sym = (disp_h == 4'd0) ? SYM_BLANK : disp_h;
      2'd3: sym = disp_sign ? SYM_DASH : SYM_BLANK;
      default: sym = SYM_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= 4'b1110;
      seg_r <= 7'b1000000;
    end else begin
      an_r  <= an_nxt;
      seg_r <= seg_code(sym);
    end
  end

  assign an  = ACTIVE_LOW ? an_r  : ~an_r;
  assign seg = ACTIVE_LOW ? seg_r : ~seg_r;
  assign dp  = ACTIVE_LOW ? 1'b1  : 1'b0;

endmodule

// File: tb/tb_signed_seg_display.sv
// tb/tb_signed_seg_display.sv - randomized self-checking bench for signed_seg_display
module tb_signed_seg_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;

  signed_seg_display_if bus();

  signed_seg_display #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .an  (an),
    .seg (seg),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [6:0] code_tab [0:11];

  // expected active-low pattern for digit d of signed value v
  function automatic logic [6:0] exp_seg(input int v, input int d);
    int m, h, t, o;
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    case (d)
      0: return code_tab[o];
      1: return (h == 0 && t == 0) ? code_tab[11] : code_tab[t];
      2: return (h == 0) ? code_tab[11] : code_tab[h];
      default: return (v < 0) ? code_tab[10] : code_tab[11];
    endcase
  endfunction

  function automatic int lit_digit(input logic [3:0] a);
    logic [3:0] pat;
    for (int k = 0; k < 4; k++) begin
      pat = ~(4'b0001 << k);
      if (a === pat) return k;
    end
    return -1;
  endfunction

  task automatic check_scan(input int v, input string nm);
    int hits [4];
    int d;
    for (int k = 0; k < 4; k++) hits[k] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      d = lit_digit(an);
      total++;
      if (d < 0) begin
        bad++;
        $display("FAIL %s an_onehot: got %b", nm, an);
      end else begin
        hits[d]++;
        total++;
        if (seg !== exp_seg(v, d)) begin
          bad++;
          $display("FAIL %s seg digit%0d: got %b want %b", nm, d, seg, exp_seg(v, d));
        end
      end
      total++;
      if (dp !== 1'b1) begin
        bad++;
        $display("FAIL %s dp: got %b want 1", nm, dp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (hits[k] != 4) begin
        bad++;
        $display("FAIL %s scan_dwell digit%0d: got %0d want 4", nm, k, hits[k]);
      end
    end
  endtask

  // strobe v, then count cycles with busy high (bounded)
  task automatic convert(input logic [7:0] v, output int n);
    @(negedge clk);
    bus.din = v;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_busy(input int n, input string nm);
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want 9", nm, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_state: got busy=%b an=%b seg=%b want 0 1110 1000000", bus.busy, an, seg);
    end
    rst = 1'b0;
    check_scan(0, "reset_scan");
  endtask

  task automatic test_directed;
    int n;
    convert(8'h7F, n); check_busy(n, "p127"); check_scan(127, "p127");
    convert(8'h80, n); check_busy(n, "m128"); check_scan(-128, "m128");
    convert(8'hFF, n); check_busy(n, "m1");   check_scan(-1, "m1");
    convert(8'h0F, n); check_busy(n, "p15");  check_scan(15, "p15");
    convert(8'h00, n); check_busy(n, "zero"); check_scan(0, "zero");
    convert(8'h64, n); check_busy(n, "p100"); check_scan(100, "p100");
  endtask

  task automatic test_random;
    int n;
    logic [7:0] v;
    for (int i = 0; i < 24; i++) begin
      v = 8'($urandom_range(0, 255));
      convert(v, n);
      check_busy(n, "rand");
      check_scan(int'($signed(v)), "rand");
    end
  endtask

  task automatic test_ignore_while_busy;
    int n, d;
    convert(8'h7F, n);
    check_busy(n, "pre127");
    @(negedge clk);
    bus.din = 8'h0F;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      d = lit_digit(an);
      total++;
      if (d < 0 || seg !== exp_seg(127, d)) begin
        bad++;
        $display("FAIL hold_old an=%b seg=%b at busy cycle %0d", an, seg, n);
      end
      if (n >= 3 && n <= 5) begin
        bus.din = 8'hFF;
        bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    check_busy(n, "ignore");
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_requeue: got busy=%b want 0", bus.busy);
    end
    check_scan(15, "ignore_result");
  endtask

  task automatic test_back_to_back;
    int n;
    convert(8'h05, n);
    check_busy(n, "b2b_first");
    // strobe immediately on the first idle cycle
    bus.din = 8'h9C;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_busy(n, "b2b_second");
    check_scan(-100, "b2b_second");
  endtask

  task automatic test_reset_mid_conv;
    int n;
    @(negedge clk);
    bus.din = 8'h64;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    n = 1;
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      bad++;
      $display("FAIL midreset: got busy=%b an=%b seg=%b want 0 1110 1000000", bus.busy, an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    check_scan(0, "midreset_scan");
    convert(8'h64, n);
    check_busy(n, "after_reset");
    check_scan(100, "after_reset");
  endtask

  initial begin
    code_tab[0]  = 7'b1000000; code_tab[1] = 7'b1111001; code_tab[2] = 7'b0100100;
    code_tab[3]  = 7'b0110000; code_tab[4] = 7'b0011001; code_tab[5] = 7'b0010010;
    code_tab[6]  = 7'b0000010; code_tab[7] = 7'b1111000; code_tab[8] = 7'b0000000;
    code_tab[9]  = 7'b0010000; code_tab[10] = 7'b0111111; code_tab[11] = 7'b1111111;
    test_reset;
    test_directed;
    test_random;
    test_ignore_while_busy;
    test_back_to_back;
    test_reset_mid_conv;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
